dist_writeback_sequencer: RTL

//  Write side of the distribution-register path. Accepts one writeback request per instruction

---
 rtl/dist_writeback_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/dist_writeback_sequencer.sv
// Serialises one NUM_BINS-wide distribution writeback into single-bin register-file writes
// and flags the in-flight destination so ID can stall on partially written registers.
module dist_writeback_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int BIN_W    = 32,
    parameter int NUM_BINS = 8,
    parameter int CNT_W    = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      wb_valid_i,
    output logic                      wb_ready_o,
    input  logic [ADDR_W-1:0]         wb_destAddr_i,
    input  logic [NUM_BINS*BIN_W-1:0] wb_dist_i,
    output logic                      rf_we_o,
    output logic [ADDR_W-1:0]         rf_addr_o,
    output logic [CNT_W-1:0]          rf_binIdx_o,
    output logic [BIN_W-1:0]          rf_data_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         busy_addr_o,
    input  logic [ADDR_W-1:0]         ID_srcAddr1_i,
    input  logic [ADDR_W-1:0]         ID_srcAddr2_i,
    output logic                      ID_distStall_o,
    output logic                      done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BIN_W-1:0]   bins_q [NUM_BINS];

    logic lastBin;
    logic accept;
    logic acceptNz;

    // Outputs decode straight from the state registers so an async reset drops them at once.
    assign lastBin  = (state_q == WRITE) && (cnt_q == CNT_W'(NUM_BINS - 1));
    assign accept   = wb_valid_i && wb_ready_o;
    assign acceptNz = accept && (wb_destAddr_i != '0);

    assign wb_ready_o     = (state_q == IDLE) || lastBin;
    assign rf_we_o        = (state_q == WRITE);
    assign rf_addr_o      = addr_q;
    assign rf_binIdx_o    = cnt_q;
    assign rf_data_o      = bins_q[cnt_q];
    assign busy_o         = (state_q == WRITE);
    assign busy_addr_o    = busy_o ? addr_q : '0;
    assign done_o         = lastBin;
    assign ID_distStall_o = busy_o && ((ID_srcAddr1_i == busy_addr_o) ||
                                       (ID_srcAddr2_i == busy_addr_o));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            for (int k = 0; k < NUM_BINS; k++) begin
                bins_q[k] <= '0;
            end
        end else begin
            if (acceptNz) begin
                addr_q <= wb_destAddr_i;
                for (int k = 0; k < NUM_BINS; k++) begin
                    bins_q[k] <= wb_dist_i[k*BIN_W +: BIN_W];
                end
            end
            case (state_q)
                IDLE: begin
                    if (acceptNz) begin
                        state_q <= WRITE;
                        cnt_q   <= '0;
                    end
                end
                WRITE: begin
                    if (!lastBin) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        // A same-edge accept on the last bin chains the next distribution with no bubble.
                        cnt_q <= '0;
                        if (!acceptNz) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
